// File: rtl/sram_cascade_pkg.sv
// Shared types and helpers for the SRAM bank cascade: controller state, bank-index width, parity.
package sram_cascade_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } cascade_state_e;

  function automatic int bank_idx_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One single-port SRAM bank: synchronous write, registered read, read data held between reads.
module sram_bank #(
  parameter int WORD_W = 4,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**AW];
  logic [WORD_W-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (cs && !we) rdata_d = mem_q[addr];
  end

  // Storage array is not reset; the controller's clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (cs && we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_bank_cascade.sv
// Vertical cascade of NUM_BANKS SRAM banks behind a valid/ready port with 1-cycle read latency.
// Optional per-word even parity with read-time checking: define SRAM_CASCADE_PARITY_EN.
module sram_bank_cascade
  import sram_cascade_pkg::*;
#(
  parameter  int DATA_W    = 4,
  parameter  int BANK_AW   = 3,
  parameter  int NUM_BANKS = 2,
  localparam int BIDX_W    = bank_idx_w(NUM_BANKS),
  localparam int ADDR_W    = BANK_AW + BIDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

`ifdef SRAM_CASCADE_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [BANK_AW-1:0] INIT_LAST = '1;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // reads answer with rsp_valid for exactly one cycle after that edge.
  cascade_state_e      state_d, state_q;
  logic [BANK_AW-1:0]  init_addr_d, init_addr_q;
  logic                ready_d, ready_q;
  logic                done_d, done_q;
  logic                rsp_valid_d, rsp_valid_q;
  logic [BIDX_W-1:0]   sel_d, sel_q;

  logic                accept;
  logic [BIDX_W-1:0]   req_bank;
  logic [NUM_BANKS-1:0] req_onehot;
  logic [NUM_BANKS-1:0] bank_cs, bank_we;
  logic [BANK_AW-1:0]  bank_addr;
  logic [WORD_W-1:0]   bank_wdata, wr_word;
  logic [WORD_W-1:0]   bank_rdata [NUM_BANKS];
  logic [WORD_W-1:0]   sel_word;

  assign accept     = req_valid && ready_q;
  assign req_bank   = req_addr[ADDR_W-1:BANK_AW];
  assign req_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << req_bank;

`ifdef SRAM_CASCADE_PARITY_EN
  assign wr_word = {even_parity(64'(req_wdata)), req_wdata};
`else
  assign wr_word = req_wdata;
`endif

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    ready_d     = ready_q;
    done_d      = done_q;
    rsp_valid_d = 1'b0;
    sel_d       = sel_q;
    bank_cs     = '0;
    bank_we     = '0;
    bank_addr   = req_addr[BANK_AW-1:0];
    bank_wdata  = wr_word;
    case (state_q)
      ST_INIT: begin
        // All banks cleared in parallel; an all-zero word has zero parity.
        bank_cs     = '1;
        bank_we     = '1;
        bank_addr   = init_addr_q;
        bank_wdata  = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == INIT_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          bank_cs = req_onehot;
          if (req_we) begin
            bank_we = req_onehot;
          end else begin
            rsp_valid_d = 1'b1;
            sel_d       = req_bank;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rsp_valid_q <= rsp_valid_d;
      sel_q       <= sel_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank #(.WORD_W(WORD_W), .AW(BANK_AW)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .cs    (bank_cs[b]),
      .we    (bank_we[b]),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // The mux follows the registered bank index so later requests cannot disturb the output.
  assign sel_word  = bank_rdata[sel_q];
  assign rsp_rdata = sel_word[DATA_W-1:0];
  assign rsp_valid = rsp_valid_q;
  assign req_ready = ready_q;
  assign init_done = done_q;

`ifdef SRAM_CASCADE_PARITY_EN
  assign rsp_err = rsp_valid_q && (sel_word[DATA_W] != (^sel_word[DATA_W-1:0]));
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank_cascade.sv
// Directed bench for sram_bank_cascade: default 2x8x4 instance plus a 4x16x8 instance.
module tb_sram_bank_cascade;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       rsp_err;
  logic       init_done;

  logic       v2 = 1'b0;
  logic       ready2;
  logic       we2 = 1'b0;
  logic [5:0] a2 = '0;
  logic [7:0] wd2 = '0;
  logic       rv2;
  logic [7:0] rd2;
  logic       err2;
  logic       done2;

  int errors = 0;
  int checks = 0;

  sram_bank_cascade dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  sram_bank_cascade #(.DATA_W(8), .BANK_AW(4), .NUM_BANKS(4)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(v2), .req_ready(ready2), .req_we(we2),
    .req_addr(a2), .req_wdata(wd2),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(err2),
    .init_done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    check($sformatf("wr_no_rsp_a%0d", a), rsp_valid, 0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] exp, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check($sformatf("rsp_valid_a%0d", a), rsp_valid, 1);
    check($sformatf("rsp_rdata_a%0d", a), rsp_rdata, exp);
    check($sformatf("rsp_err_a%0d", a), rsp_err, exp_err);
  endtask

  task automatic write2(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    v2 = 1'b1; we2 = 1'b1; a2 = a; wd2 = d;
    @(posedge clk); #1;
    v2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic read2(input logic [5:0] a, input logic [7:0] exp);
    @(negedge clk);
    v2 = 1'b1; we2 = 1'b0; a2 = a;
    @(posedge clk); #1;
    v2 = 1'b0;
    check($sformatf("w_rsp_valid_a%0h", a), rv2, 1);
    check($sformatf("w_rsp_rdata_a%0h", a), rd2, exp);
  endtask

  initial begin
    // Reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_init_done", init_done, 0);

    // Release reset with a write to addr 5 held during INIT; it must be ignored
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("init_ready_c%0d", i), req_ready, (i == 8) ? 1 : 0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    check("init_done", init_done, 1);

    for (int a = 0; a < 16; a++) do_read(4'(a), 4'h0, 1'b0);

    // Cross-bank writes, then back-to-back reads
    do_write(4'd3, 4'hA);
    do_write(4'd11, 4'h5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    @(posedge clk); #1;
    req_addr = 4'd11;
    check("b2b_valid0", rsp_valid, 1);
    check("b2b_rdata0", rsp_rdata, 4'hA);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_valid1", rsp_valid, 1);
    check("b2b_rdata1", rsp_rdata, 4'h5);
    @(posedge clk); #1;
    check("idle_valid", rsp_valid, 0);
    check("idle_hold", rsp_rdata, 4'h5);

    // Write followed immediately by a read of the same address
    do_write(4'd6, 4'h7);
    do_read(4'd6, 4'h7, 1'b0);
    do_read(4'd3, 4'hA, 1'b0);
    do_read(4'd5, 4'h0, 1'b0);

`ifdef SRAM_CASCADE_PARITY_EN
    do_write(4'd2, 4'h3);
    dut.g_bank[0].u_bank.mem_q[2][0] = ~dut.g_bank[0].u_bank.mem_q[2][0];
    do_read(4'd2, 4'h2, 1'b1);
    do_read(4'd11, 4'h5, 1'b0);
`endif

    // Reset between read accept and its response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd11;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_done", init_done, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i <= 8) check($sformatf("reinit_ready_c%0d", i), req_ready, (i == 8) ? 1 : 0);
      check($sformatf("wide_ready_c%0d", i), ready2, (i == 16) ? 1 : 0);
    end
    check("reinit_rsp_valid", rsp_valid, 0);
    do_read(4'd3, 4'h0, 1'b0);
    do_read(4'd11, 4'h0, 1'b0);
    do_read(4'd6, 4'h0, 1'b0);

    // Four-bank, 16-deep, 8-bit instance
    check("wide_done", done2, 1);
    write2(6'h3F, 8'hC3);
    write2(6'h0F, 8'h11);
    write2(6'h1F, 8'h22);
    write2(6'h2F, 8'h33);
    read2(6'h3F, 8'hC3);
    read2(6'h0F, 8'h11);
    read2(6'h1F, 8'h22);
    read2(6'h2F, 8'h33);
    read2(6'h30, 8'h00);
    check("wide_err", err2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
